// File: rtl/add8_share_sched_pkg.sv
// Shared opcodes and sequencer state encoding for the shared-adder scheduler.
package add8_share_sched_pkg;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_TWO_OPS = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC1 = 2'd1,
    EXEC2 = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/add8_share_sched_add_cin_unit.sv
// Single WIDTH-bit adder with carry-in; carry-out is dropped.
module add_cin_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             CIN,
  output logic [WIDTH-1:0] O
);

  assign O = I0 + I1 + WIDTH'(CIN);

endmodule

// File: rtl/add8_share_sched.sv
// Round-robin arbiter plus sequencer that time-shares one carry-in adder
// between NREQ requesters (ADD, SUB, and two-pass TWO_OPS).
module add8_share_sched
  import add8_share_sched_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 2,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_I0,
  input  logic [WIDTH*NREQ-1:0] req_I1,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_O,
  output state_t                state_dbg
);

  // Handshakes: a transfer happens on a rising CLK edge where valid and ready
  // are both high. req_ready is one-hot (or zero) and only asserted in IDLE;
  // rsp_O/rsp_id hold steady while rsp_valid waits for rsp_ready.

  state_t           state, state_next;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
  logic             grant_found;
  logic             accept;

  logic [WIDTH-1:0] a_q, b_q, acc;
  logic [1:0]       op_q;
  logic [IDW-1:0]   id_q;

  logic [WIDTH-1:0] add_i0, add_i1, add_o;
  logic             add_cin;

  // Upward search starting just after the last winner, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(last_grant) + i) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign accept = (state == IDLE) && grant_found && !RESET;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_found) state_next = EXEC1;
      EXEC1:   state_next = (op_q == OP_TWO_OPS) ? EXEC2 : RESP;
      EXEC2:   state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Adder input mux; subtraction is a + ~b + 1. Reserved opcode falls into ADD.
  always_comb begin
    add_i0  = '0;
    add_i1  = '0;
    add_cin = 1'b0;
    case (state)
      EXEC1: begin
        add_i0  = a_q;
        add_i1  = (op_q == OP_SUB) ? ~b_q : b_q;
        add_cin = (op_q == OP_SUB);
      end
      EXEC2: begin
        add_i0  = acc;
        add_i1  = ~a_q;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  add_cin_unit #(.WIDTH(WIDTH)) u_add (
    .I0  (add_i0),
    .I1  (add_i1),
    .CIN (add_cin),
    .O   (add_o)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      last_grant <= IDW'(NREQ - 1);
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      id_q       <= '0;
      acc        <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_q        <= req_I0[int'(grant_idx)*WIDTH +: WIDTH];
        b_q        <= req_I1[int'(grant_idx)*WIDTH +: WIDTH];
        op_q       <= req_op[int'(grant_idx)*2 +: 2];
        id_q       <= grant_idx;
        last_grant <= grant_idx;
      end
      if (state == EXEC1 || state == EXEC2) acc <= add_o;
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_O     = acc;
  assign rsp_id    = id_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_add8_share_sched.sv
// Bench for add8_share_sched: directed cases plus random traffic checked by a
// transaction-level model (round-robin order, latency rules, plain arithmetic).
module tb_add8_share_sched;
  import add8_share_sched_pkg::*;

  localparam int WIDTH = 8;
  localparam int NREQ  = 2;
  localparam int IDW   = 1;
  localparam int QW    = IDW + WIDTH;

  logic                  CLK = 1'b0;
  logic                  RESET = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op = '0;
  logic [WIDTH*NREQ-1:0] req_I0 = '0;
  logic [WIDTH*NREQ-1:0] req_I1 = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_O;
  state_t                state_dbg;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  add8_share_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_I0    (req_I0),
    .req_I1    (req_I1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_O     (rsp_O),
    .state_dbg (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [WIDTH-1:0] ref_result(input logic [1:0] op, input int i0, input int i1);
    int r;
    case (op)
      2'b01:   r = i0 - i1;
      2'b10:   r = (i0 + i1) - i0;
      default: r = i0 + i1;
    endcase
    return WIDTH'(r & ((1 << WIDTH) - 1));
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [QW-1:0] exp_q[$];
  bit            model_idle = 1'b1;
  int            model_ptr  = NREQ - 1;
  int            model_due  = 0;
  int            cyc        = 0;

  always @(negedge CLK) begin
    int            g;
    bit            found;
    logic [1:0]    op;
    logic [QW-1:0] head;
    bit            exp_v;
    cyc++;
    if (RESET) begin
      check("rst_ready", req_ready, 0);
      exp_q.delete();
      model_idle = 1'b1;
      model_ptr  = NREQ - 1;
    end else if (model_idle) begin
      found = 1'b0;
      g     = 0;
      for (int j = 1; j <= NREQ; j++) begin
        if (!found && req_valid[(model_ptr + j) % NREQ]) begin
          found = 1'b1;
          g     = (model_ptr + j) % NREQ;
        end
      end
      check("grant", req_ready, found ? (1 << g) : 0);
      check("idle_rsp_valid", rsp_valid, 0);
      if (found) begin
        op = req_op[2*g +: 2];
        exp_q.push_back({IDW'(g),
                         ref_result(op, int'(req_I0[WIDTH*g +: WIDTH]), int'(req_I1[WIDTH*g +: WIDTH]))});
        model_due  = cyc + ((op == 2'b10) ? 3 : 2);
        model_ptr  = g;
        model_idle = 1'b0;
      end
    end else begin
      check("busy_ready", req_ready, 0);
      exp_v = (cyc >= model_due);
      check("rsp_valid", rsp_valid, exp_v);
      if (exp_v && exp_q.size() > 0) begin
        head = exp_q[0];
        check("rsp_O", rsp_O, head[WIDTH-1:0]);
        check("rsp_id", rsp_id, head[QW-1:WIDTH]);
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          model_idle = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int k, input logic [1:0] op,
                         input logic [WIDTH-1:0] i0, input logic [WIDTH-1:0] i1);
    req_op[2*k +: 2]         = op;
    req_I0[WIDTH*k +: WIDTH] = i0;
    req_I1[WIDTH*k +: WIDTH] = i1;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RESET     = 1'b1;
    req_valid = '0;
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  task automatic directed(input string tag, input int k, input logic [1:0] op,
                          input logic [WIDTH-1:0] i0, input logic [WIDTH-1:0] i1,
                          input logic [WIDTH-1:0] exp_o, input int exp_lat);
    int lat;
    @(posedge CLK); #1;
    req_valid    = '0;
    req_valid[k] = 1'b1;
    set_req(k, op, i0, i1);
    @(negedge CLK);
    check({tag, "_ready"}, req_ready, 1 << k);
    @(posedge CLK); #1;
    req_valid = '0;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!rsp_valid && lat < 8);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_O"}, rsp_O, exp_o);
    check({tag, "_id"}, rsp_id, k);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   n;
    int   prev_t;
    logic [WIDTH-1:0] held_o;

    rsp_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("reset_O", rsp_O, 0);
    check("reset_id", rsp_id, 0);
    check("reset_state", state_dbg, IDLE);
    check("reset_valid", rsp_valid, 0);

    directed("add_wrap",   0, OP_ADD,     8'hFF, 8'h02, 8'h01, 2);
    directed("sub_borrow", 1, OP_SUB,     8'h03, 8'h05, 8'hFE, 2);
    directed("two_ops_a",  0, OP_TWO_OPS, 8'hF0, 8'h20, 8'h20, 3);
    directed("two_ops_b",  0, OP_TWO_OPS, 8'h05, 8'h03, 8'h03, 3);
    directed("rsvd_add",   1, OP_RSVD,    8'h80, 8'h81, 8'h01, 2);

    // Both requesters hammering ADD right after reset: 0,1,0,1 every 3 cycles.
    do_reset();
    set_req(0, OP_ADD, 8'h11, 8'h22);
    set_req(1, OP_ADD, 8'h33, 8'h44);
    req_valid = 2'b11;
    prev_t = 0;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin
        @(negedge CLK);
        n++;
      end while (req_ready == '0 && n < 20);
      check("arb_grant", req_ready, (g % 2 == 1) ? 2'b10 : 2'b01);
      if (g > 0) check("arb_space", ($time - prev_t) / 10, 3);
      prev_t = int'($time);
    end
    @(posedge CLK); #1;
    req_valid = '0;
    repeat (4) @(posedge CLK);

    // Backpressure: hold the response for three cycles while req1 waits.
    #1;
    rsp_ready = 1'b0;
    set_req(0, OP_ADD, 8'h10, 8'h22);
    req_valid = 2'b01;
    @(negedge CLK);
    check("bp_accept", req_ready, 2'b01);
    @(posedge CLK); #1;
    set_req(1, OP_ADD, 8'h01, 8'h01);
    req_valid = 2'b10;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!rsp_valid && n < 8);
    held_o = 8'h32;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_O", rsp_O, held_o);
      check("bp_id", rsp_id, 0);
      check("bp_ready", req_ready, 0);
      if (i < 2) @(negedge CLK);
    end
    @(posedge CLK); #1;
    rsp_ready = 1'b1;
    @(negedge CLK);
    check("bp_hs_valid", rsp_valid, 1);
    check("bp_hs_O", rsp_O, held_o);
    @(negedge CLK);
    check("bp_after_state", state_dbg, IDLE);
    check("bp_after_ready", req_ready, 2'b10);
    @(posedge CLK); #1;
    req_valid = '0;
    repeat (4) @(posedge CLK);

    // Reset while a TWO_OPS sits in its second pass.
    #1;
    set_req(1, OP_ADD, 8'h05, 8'h06);
    set_req(0, OP_TWO_OPS, 8'h44, 8'h55);
    req_valid = 2'b01;
    @(negedge CLK);
    check("rst_mid_accept", req_ready, 2'b01);
    @(posedge CLK); #1;
    req_valid = '0;
    @(posedge CLK); #1;
    check("rst_mid_exec2", state_dbg, EXEC2);
    RESET = 1'b1;
    set_req(0, OP_ADD, 8'h01, 8'h02);
    req_valid = 2'b11;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_mid_valid", rsp_valid, 0);
    check("rst_mid_state", state_dbg, IDLE);
    check("rst_mid_grant", req_ready, 2'b01);
    @(posedge CLK); #1;
    req_valid = '0;
    repeat (4) @(posedge CLK);

    // Random traffic, all checking done by the monitor.
    for (int c = 0; c < 600; c++) begin
      #1;
      req_valid = NREQ'($urandom_range(0, 3));
      for (int k = 0; k < NREQ; k++)
        set_req(k, 2'($urandom_range(0, 3)), WIDTH'($urandom), WIDTH'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge CLK);
    end
    #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/add8_share_sched.md
Name: add8_share_sched

Overview:
- Sequencer and arbiter that shares one WIDTH-bit carry-in adder between NREQ requesters.
- Each request is one of three operations:
  - add: I0+I1
  - sub: I0-I1, computed as I0 + ~I1 + 1
  - two_ops: (I0+I1)-I0, computed in two adder passes
- Sits in front of the adder/subtractor datapath, so several clients can use one adder instead of instantiating their own.

Parameters:
- WIDTH, 8, operand and result width in bits.
- NREQ, 2, number of requesters (≥2). IDW = max(1, $clog2(NREQ)).

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept, one-hot or zero.
- req_op  input  2*NREQ  per-requester opcode; requester k uses bits [2k+1:2k].
- req_I0  input  WIDTH*NREQ  per-requester operand I0, packed by index.
- req_I1  input  WIDTH*NREQ  per-requester operand I1, packed by index.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  result consumer ready.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_O  output  WIDTH  result.

Behaviour:
- Opcodes:
  - 2'b00 = ADD, 2'b01 = SUB, 2'b10 = TWO_OPS.
  - 2'b11 is reserved and executes as ADD.
- All arithmetic is modulo 2^WIDTH; carry-out is discarded.
- FSM states: IDLE, EXEC1, EXEC2, RESP.
- IDLE:
  - Round-robin grant g = first requester with req_valid set, searching upward (wrapping) from last_grant+1.
  - req_ready[g] is asserted combinationally, only in IDLE and only when req_valid[g]=1.
  - On acceptance, capture a=I0, b=I1, op, id=g; set last_grant=g; go to EXEC1.
  - With no valid requester, remain in IDLE.
- EXEC1 (one adder pass, result into acc):
  - ADD and TWO_OPS: acc = a + b, CIN=0.
  - SUB: acc = a + ~b, CIN=1.
  - TWO_OPS goes to EXEC2; all other ops go to RESP.
- EXEC2: acc = acc + ~a, CIN=1; go to RESP.
- RESP:
  - rsp_valid=1; rsp_O=acc and rsp_id=id, both held stable until rsp_ready=1.
  - On the handshake cycle, go to IDLE.
  - No new request is accepted in RESP; the next accept is possible in the following IDLE cycle.
- Latency, with the accept edge at t:
  - ADD/SUB: rsp_valid high from cycle t+2.
  - TWO_OPS: rsp_valid high from cycle t+3.
- Minimum spacing between accepts is 3 cycles for ADD/SUB and 4 for TWO_OPS.
- Only one adder instance exists; its inputs are muxed by state. Outside EXEC1 and EXEC2 its output is unused.
- Reset values:
  - state=IDLE, last_grant=NREQ-1, so requester 0 wins first.
  - rsp_valid=0, rsp_O=0, rsp_id=0, acc=0.
  - req_ready=0 during the reset cycle.
- Reset mid-operation: the in-flight op is dropped, no response is produced, and the round-robin pointer is restored to NREQ-1.
- A requester that drops req_valid before acceptance is simply skipped; no state is held for it.
- Simultaneous valids: exactly one grant per IDLE cycle. The others wait; round-robin guarantees each is served within NREQ transactions.
- rsp_ready asserted while not in RESP is ignored.

Decomposition:
- Shared package holds:
  - opcode localparams: OP_ADD, OP_SUB, OP_TWO_OPS, OP_RSVD.
  - state enum: IDLE, EXEC1, EXEC2, RESP.
- One sub-module, add_cin_unit (WIDTH; I0, I1, CIN, O), O = I0 + I1 + CIN truncated to WIDTH bits, purely combinational.
- Arbiter and FSM stay in add8_share_sched.

Test Plan:
- ADD wrap: req0 op=00, I0=0xFF, I1=0x02, rsp_ready=1.
  - rsp_valid at t+2 with rsp_O=0x01, rsp_id=0.
- SUB borrow: req1 op=01, I0=0x03, I1=0x05.
  - rsp_O=0xFE, rsp_id=1, at t+2.
- TWO_OPS: req0 op=10, I0=0xF0, I1=0x20.
  - EXEC1 acc=0x10, then rsp_O=0x20 at t+3.
  - With I0=0x05, I1=0x03: rsp_O=0x03.
- Arbitration after reset: req0 and req1 both valid continuously with ADD.
  - Grants in order 0,1,0,1.
  - First response rsp_id=0; accepts spaced exactly 3 cycles apart.
- Backpressure: rsp_ready=0 for 3 cycles in RESP.
  - rsp_valid, rsp_O and rsp_id stay stable; req_ready=0 throughout.
  - The handshake completes on the cycle rsp_ready rises; IDLE follows.
- Reset mid-op: RESET=1 during EXEC2 of a TWO_OPS.
  - Next cycle: rsp_valid=0, state IDLE.
  - With req0 and req1 both valid, requester 0 is granted first.
